// File: rtl/seq_mult_nbit.sv
// Sequential shift-add multiplier, signed or unsigned operands.
// One partial product per clock; the result lands in product with a one-cycle done pulse.
module seq_mult_nbit #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product,
    output logic               busy,
    output logic               done
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [PW-1:0]    acc;
    logic [CW-1:0]    cnt;
    logic             neg;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [PW-1:0]    acc_next;
    logic [PW-1:0]    result;

    // Negating -2^(WIDTH-1) yields 2^(WIDTH-1) as an unsigned magnitude, which is what we want.
    always_comb begin
        a_mag    = (signed_mode && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
        b_mag    = (signed_mode && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
        acc_next = acc + (mplier[0] ? ({{WIDTH{1'b0}}, mcand} << cnt) : '0);
        result   = neg ? (~acc_next + PW'(1)) : acc_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
            neg     <= 1'b0;
            product <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= a_mag;
                        mplier <= b_mag;
                        neg    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                        acc    <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    acc    <= acc_next;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        product <= result;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult_nbit.sv
// Self-checking bench for seq_mult_nbit (WIDTH=8): directed corner cases plus
// randomized operands compared against an arithmetic reference model.
module tb_seq_mult_nbit;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           signed_mode;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] product;
    logic           busy;
    logic           done;

    int tests = 0;
    int fails = 0;

    seq_mult_nbit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
        .a(a), .b(b), .product(product), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2*W-1:0] ref_mult(input logic [W-1:0] x, input logic [W-1:0] y, input logic sm);
        longint p;
        if (sm) p = longint'($signed(x)) * longint'($signed(y));
        else    p = longint'(x) * longint'(y);
        return p[2*W-1:0];
    endfunction

    // Call at #1 after the accepting edge, with start already low.
    task automatic wait_done(input string tag, input logic [2*W-1:0] exp);
        int lat;
        bit busy_ok;
        lat = 0;
        busy_ok = 1'b1;
        while (!done && lat < 20) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, lat, W);
        check({tag, "_busy"}, busy_ok, 1);
        check({tag, "_prod"}, product, exp);
        check({tag, "_busy_low"}, busy, 0);
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_hold"}, product, exp);
    endtask

    task automatic do_mult(input string tag, input logic [W-1:0] x, input logic [W-1:0] y, input logic sm);
        @(negedge clk);
        a = x; b = y; signed_mode = sm; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); signed_mode = 1'($urandom);
        wait_done(tag, ref_mult(x, y, sm));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, dones;
        int dcyc[2];
        logic [2*W-1:0] dprod[2];
        logic [2*W-1:0] last_prod;
        logic [W-1:0] rx, ry;
        logic rs;

        rst = 1'b1; start = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_product", product, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(negedge clk) rst = 1'b0;

        do_mult("uns_ff_ff", 8'hFF, 8'hFF, 1'b0);
        check("uns_ff_ff_const", product, 16'hFE01);
        do_mult("sgn_80_80", 8'h80, 8'h80, 1'b1);
        check("sgn_80_80_const", product, 16'h4000);
        do_mult("sgn_fd_05", 8'hFD, 8'h05, 1'b1);
        check("sgn_fd_05_const", product, 16'hFFF1);
        do_mult("uns_fd_05", 8'hFD, 8'h05, 1'b0);
        check("uns_fd_05_const", product, 16'h04F1);
        do_mult("zero_7f", 8'h00, 8'h7F, 1'b0);

        // start while busy is ignored; operand changes mid-run are ignored
        @(negedge clk);
        a = 8'd3; b = 8'd4; signed_mode = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = 8'hAA; b = 8'h55;
        repeat (2) @(posedge clk);
        #1;
        a = 8'd9; b = 8'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = 8'h11; b = 8'hEE; signed_mode = 1'b1;
        dones = 0; last_prod = '0;
        for (int i = 0; i < 16; i++) begin
            if (done) begin dones++; last_prod = product; end
            @(posedge clk); #1;
        end
        check("busy_start_dones", dones, 1);
        check("busy_start_prod", last_prod, 16'h000C);

        // back-to-back with start held high
        @(negedge clk);
        a = 8'd7; b = 8'd6; signed_mode = 1'b0; start = 1'b1;
        @(negedge clk);
        a = 8'h10; b = 8'h10;
        n = 0; dones = 0;
        while (dones < 2 && n < 40) begin
            @(negedge clk);
            n++;
            if (done) begin
                dcyc[dones] = n;
                dprod[dones] = product;
                dones++;
                if (dones == 2) start = 1'b0;
            end
        end
        check("b2b_dones", dones, 2);
        check("b2b_first_lat", dcyc[0], W);
        check("b2b_spacing", dcyc[1] - dcyc[0], W + 1);
        check("b2b_prod0", dprod[0], 16'h002A);
        check("b2b_prod1", dprod[1], 16'h0100);
        @(posedge clk); #1;
        check("b2b_idle_after", busy, 0);

        // reset mid-run aborts; start honoured on first edge after release
        @(negedge clk);
        a = 8'hFF; b = 8'hFF; signed_mode = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_product", product, 0);
        a = 8'd2; b = 8'd3; start = 1'b1;
        @(posedge clk); #1;
        check("rst_hold_busy", busy, 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_accept", busy, 1);
        check("post_rst_no_done", done, 0);
        start = 1'b0;
        wait_done("post_rst_2x3", 16'h0006);

        for (int i = 0; i < 40; i++) begin
            rx = W'($urandom);
            ry = W'($urandom);
            rs = 1'($urandom);
            if (i % 8 == 0) rx = 8'h80;
            if (i % 8 == 1) ry = 8'h00;
            do_mult($sformatf("rnd%0d", i), rx, ry, rs);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seq_mult_nbit.md
SEQ_MULT_NBIT -- requirements
Module: seq_mult_nbit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal range 2..32.
REQ-002 The block SHALL have port clk, input, 1 bit: clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request a new multiply.
REQ-005 The block SHALL have port signed_mode, input, 1 bit: 1 = two's-complement operands, 0 = unsigned.
REQ-006 The block SHALL have port a, input, WIDTH bits: multiplicand.
REQ-007 The block SHALL have port b, input, WIDTH bits: multiplier.
REQ-008 The block SHALL have port product, output, 2*WIDTH bits: result register.
REQ-009 The block SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-010 The block SHALL have port done, output, 1 bit: single-cycle result-valid pulse.

Function
REQ-011 The state machine SHALL have states IDLE and RUN; RUN SHALL use a step counter of ceil(log2(WIDTH))+1 bits.
REQ-012 In IDLE, start=1 at a rising edge (edge k) SHALL be accepted, with the following effects:
- a, b and signed_mode captured;
- accumulator and counter cleared;
- state moves to RUN and busy goes to 1.
REQ-013 Operand capture SHALL convert to magnitudes: if signed_mode=1, each operand with MSB=1 is replaced by its two's-complement negation as a WIDTH-bit unsigned value (-2^(WIDTH-1) maps to 2^(WIDTH-1)).
REQ-014 The result sign SHALL be a[MSB] XOR b[MSB] when signed_mode=1, and 0 otherwise.
REQ-015 Each RUN edge SHALL perform one shift-add step:
- if the current multiplier LSB = 1, add the magnitude multiplicand shifted left by the step count to the 2*WIDTH-bit accumulator;
- shift the multiplier right by 1;
- increment the counter.
REQ-016 Accumulation SHALL be exact in 2*WIDTH bits; no overflow is possible for any operand pair.
REQ-017 At the WIDTH-th RUN edge (edge k+WIDTH), the block SHALL:
- load product with the final accumulator, two's-complement negated in 2*WIDTH bits if the result sign = 1;
- set done=1 and busy=0;
- return to IDLE.
REQ-018 Latency SHALL be exactly WIDTH clocks from the accepting edge to the edge that asserts done.
REQ-019 done SHALL be high for exactly one cycle per accepted operation.
REQ-020 product SHALL hold its value until the next completion or reset.
REQ-021 start while busy=1 SHALL be ignored; the operation in flight SHALL be unaffected.
REQ-022 Changes on a, b or signed_mode after the accepting edge SHALL NOT affect the operation in flight.
REQ-023 start=1 during the cycle done=1 SHALL be accepted (back-to-back), giving a throughput of one result per WIDTH+1 clocks.
REQ-024 Holding start=1 continuously SHALL restart the multiplier on every IDLE cycle.
REQ-025 Zero operands SHALL still take the full WIDTH cycles; there is no early termination.

Reset
REQ-026 While rst=1, the block SHALL hold: product=0, done=0, busy=0, state IDLE, counter=0, accumulator=0.
REQ-027 Reset asserted mid-operation SHALL abort the operation immediately.
REQ-028 No done pulse SHALL follow an aborted operation, and product SHALL read 0.
REQ-029 start SHALL be honoured only on the first rising edge after rst deasserts.

Verification (WIDTH=8)
REQ-030 Unsigned, a=0xFF, b=0xFF, start pulsed -> 8 clocks later done=1 and product=0xFE01; busy high for the 8 intervening cycles.
REQ-031 Signed, a=0x80, b=0x80 -> product=0x4000; signed a=0xFD (-3), b=0x05 -> product=0xFFF1 (-15).
REQ-032 Mode check, a=0xFD, b=0x05 with signed_mode=0 -> product=0x04F1 (1265); a=0x00, b=0x7F -> product=0x0000 after 8 clocks.
REQ-033 Start 3*4, then pulse start with a=9, b=9 at cycle 3 while busy, and change a/b mid-run -> product=0x000C, exactly one done.
REQ-034 Back-to-back: start held high, operands 7*6 then 0x10*0x10 -> done pulses 9 clocks apart; products 0x002A then 0x0100.
REQ-035 rst asserted at cycle 4 of a 0xFF*0xFF run -> busy=0, done stays 0, product=0; a new 2*3 after release -> product=0x0006.
